sha1_multiblock_seq: RTL and testbench

Parametrised successor to the single-block SHA-1 sequencer/top pairing. It latches a message of up to MAX_BLOCKS padded 512-bit blocks, streams each block word-serially into the sha1_exec core, and chains the chaining value between blocks automatically. It exposes a sticky done flag and the final digest, and supports abort. It sits between the AXI-side register file and sha1_exec, replacing the one-block sequencer.

---
 rtl/sha1_multiblock_seq.sv | 186 ++++++++++++++++++
 tb/tb_sha1_multiblock_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_multiblock_seq.sv
// rtl/sha1_multiblock_seq.sv - multi-block SHA-1 job sequencer feeding sha1_exec word-serially
module sha1_multiblock_seq #(
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int MAX_BLOCKS  = 4,
    parameter int CV_W        = 160,
    parameter int NB_W        = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic                                     abort,
    input  logic [NB_W-1:0]                          num_blocks,
    input  logic [MAX_BLOCKS*BLOCK_WORDS*WORD_W-1:0] data_i,
    input  logic [CV_W-1:0]                          cv_init,
    output logic                                     busy,
    output logic                                     done,
    output logic [CV_W-1:0]                          cv_out,
    output logic                                     core_start,
    output logic                                     core_load,
    output logic [WORD_W-1:0]                        core_data,
    output logic                                     core_use_prev_cv,
    output logic [CV_W-1:0]                          core_cv,
    input  logic                                     core_busy,
    input  logic                                     core_out_valid,
    input  logic [CV_W-1:0]                          core_cv_next
);

    localparam int TOT_WORDS = MAX_BLOCKS * BLOCK_WORDS;
    localparam int AW        = (TOT_WORDS > 1) ? $clog2(TOT_WORDS) : 1;
    localparam int WRD_W     = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [NB_W-1:0]  MAX_NB   = NB_W'(MAX_BLOCKS);
    localparam logic [WRD_W-1:0] LAST_WRD = WRD_W'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_KICK, S_LOAD, S_WAIT, S_FIN} state_t;

    state_t                          state_q, state_d;
    logic [TOT_WORDS-1:0][WORD_W-1:0] msg_q, msg_d;
    logic [NB_W-1:0]                 nb_q, nb_d;
    logic [NB_W-1:0]                 blk_q, blk_d;
    logic [WRD_W-1:0]                wrd_q, wrd_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic [CV_W-1:0]                 cv_out_q, cv_out_d;
    logic                            core_start_q, core_start_d;
    logic                            core_load_q, core_load_d;
    logic [WORD_W-1:0]               core_data_q, core_data_d;
    logic                            core_use_prev_cv_q, core_use_prev_cv_d;
    logic [CV_W-1:0]                 core_cv_q, core_cv_d;
    logic [NB_W-1:0]                 nb_clamped;
    logic                            unused_core_busy;

    // The core's busy flag is informational; sequencing relies on out_valid alone.
    assign unused_core_busy = core_busy;
    assign nb_clamped       = (num_blocks > MAX_NB) ? MAX_NB : num_blocks;

    function automatic logic [AW-1:0] word_addr(input logic [NB_W-1:0] b, input logic [WRD_W-1:0] w);
        return AW'(b) * AW'(BLOCK_WORDS) + AW'(w);
    endfunction

    always_comb begin
        state_d            = state_q;
        msg_d              = msg_q;
        nb_d               = nb_q;
        blk_d              = blk_q;
        wrd_d              = wrd_q;
        busy_d             = busy_q;
        done_d             = done_q;
        cv_out_d           = cv_out_q;
        core_start_d       = 1'b0;
        core_load_d        = core_load_q;
        core_data_d        = core_data_q;
        core_use_prev_cv_d = core_use_prev_cv_q;
        core_cv_d          = core_cv_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    msg_d     = data_i;
                    core_cv_d = cv_init;
                    nb_d      = nb_clamped;
                    done_d    = 1'b0;
                    blk_d     = '0;
                    wrd_d     = '0;
                    if (nb_clamped == '0) begin
                        state_d  = S_FIN;
                        cv_out_d = cv_init;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        state_d            = S_KICK;
                        busy_d             = 1'b1;
                        core_start_d       = 1'b1;
                        core_use_prev_cv_d = 1'b0;
                    end
                end
            end
            S_KICK: begin
                state_d     = S_LOAD;
                wrd_d       = '0;
                core_load_d = 1'b1;
                core_data_d = msg_q[word_addr(blk_q, '0)];
            end
            S_LOAD: begin
                if (wrd_q == LAST_WRD) begin
                    state_d     = S_WAIT;
                    core_load_d = 1'b0;
                    core_data_d = '0;
                end else begin
                    wrd_d       = wrd_q + WRD_W'(1);
                    core_data_d = msg_q[word_addr(blk_q, wrd_d)];
                end
            end
            S_WAIT: begin
                if (core_out_valid) begin
                    cv_out_d = core_cv_next;
                    if (blk_q == nb_q - NB_W'(1)) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        blk_d              = blk_q + NB_W'(1);
                        wrd_d              = '0;
                        state_d            = S_KICK;
                        core_start_d       = 1'b1;
                        core_use_prev_cv_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort drops the job immediately; the core runs on and its result is discarded.
        if (abort && (state_q == S_KICK || state_q == S_LOAD || state_q == S_WAIT)) begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            core_start_d = 1'b0;
            core_load_d  = 1'b0;
            core_data_d  = '0;
            cv_out_d     = cv_out_q;
            blk_d        = '0;
            wrd_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= S_IDLE;
            msg_q              <= '0;
            nb_q               <= '0;
            blk_q              <= '0;
            wrd_q              <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            cv_out_q           <= '0;
            core_start_q       <= 1'b0;
            core_load_q        <= 1'b0;
            core_data_q        <= '0;
            core_use_prev_cv_q <= 1'b0;
            core_cv_q          <= '0;
        end else begin
            state_q            <= state_d;
            msg_q              <= msg_d;
            nb_q               <= nb_d;
            blk_q              <= blk_d;
            wrd_q              <= wrd_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            cv_out_q           <= cv_out_d;
            core_start_q       <= core_start_d;
            core_load_q        <= core_load_d;
            core_data_q        <= core_data_d;
            core_use_prev_cv_q <= core_use_prev_cv_d;
            core_cv_q          <= core_cv_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign cv_out           = cv_out_q;
    assign core_start       = core_start_q;
    assign core_load        = core_load_q;
    assign core_data        = core_data_q;
    assign core_use_prev_cv = core_use_prev_cv_q;
    assign core_cv          = core_cv_q;

endmodule

// File: tb/tb_sha1_multiblock_seq.sv
// tb/tb_sha1_multiblock_seq.sv - bench with a SHA-1 core model and a chained-digest reference
module tb_sha1_multiblock_seq;

    localparam int CORE_LAT = 5;
    localparam logic [159:0] H_STD = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    logic         clk = 1'b0;
    logic         reset, start, abort;
    logic [2:0]   num_blocks;
    logic [2047:0] data_i;
    logic [159:0] cv_init;
    logic         busy, done, core_start, core_load, core_use_prev_cv;
    logic [159:0] cv_out, core_cv;
    logic [31:0]  core_data;
    logic         core_busy, core_valid_m, inj_valid;
    logic [159:0] core_cv_m, inj_cv;
    wire          core_out_valid = core_valid_m | inj_valid;
    wire  [159:0] core_cv_next   = inj_valid ? inj_cv : core_cv_m;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  tb_words [64];
    logic [31:0]  m_words  [64];
    int           m_nb, m_start_cnt, m_load_idx;
    logic [159:0] m_cv_init, m_digest;
    logic [31:0]  m_first_word;

    sha1_multiblock_seq dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_blocks(num_blocks),
        .data_i(data_i), .cv_init(cv_init), .busy(busy), .done(done), .cv_out(cv_out),
        .core_start(core_start), .core_load(core_load), .core_data(core_data),
        .core_use_prev_cv(core_use_prev_cv), .core_cv(core_cv), .core_busy(core_busy),
        .core_out_valid(core_out_valid), .core_cv_next(core_cv_next)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [159:0] sha1_compress(input logic [159:0] cv, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = blk[i*32 +: 32];
        for (int i = 16; i < 80; i++) w[i] = rotl(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
        a = cv[159:128]; b = cv[127:96]; c = cv[95:64]; d = cv[63:32]; e = cv[31:0];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            t = rotl(a, 5) + f + e + k + w[i];
            e = d; d = c; c = rotl(b, 30); b = a; a = t;
        end
        return {cv[159:128] + a, cv[127:96] + b, cv[95:64] + c, cv[63:32] + d, cv[31:0] + e};
    endfunction

    function automatic logic [511:0] m_block(input int b);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = m_words[b*16 + k];
        return r;
    endfunction

    function automatic logic [159:0] model_chain(input logic [159:0] cv, input int nb);
        for (int b = 0; b < nb; b++) cv = sha1_compress(cv, m_block(b));
        return cv;
    endfunction

    // Behavioural sha1_exec: collects 16 words after core_start, answers CORE_LAT cycles later.
    logic [511:0] cm_blk;
    logic [159:0] cm_base, cm_prev;
    int           cm_nw, cm_cnt;
    initial begin
        core_valid_m = 1'b0; core_cv_m = '0; core_busy = 1'b0;
        cm_prev = '0; cm_base = '0; cm_blk = '0; cm_nw = 16; cm_cnt = 0;
        forever begin
            @(negedge clk);
            core_valid_m = 1'b0;
            if (cm_cnt > 0) begin
                cm_cnt--;
                if (cm_cnt == 0) begin
                    core_cv_m    = sha1_compress(cm_base, cm_blk);
                    core_valid_m = 1'b1;
                    cm_prev      = core_cv_m;
                    core_busy    = 1'b0;
                end
            end
            if (core_start) begin
                cm_base   = core_use_prev_cv ? cm_prev : core_cv;
                cm_nw     = 0;
                cm_cnt    = 0;
                core_busy = 1'b1;
            end
            if (core_load && cm_nw < 16) begin
                cm_blk[cm_nw*32 +: 32] = core_data;
                cm_nw++;
                if (cm_nw == 16) cm_cnt = CORE_LAT;
            end
        end
    end

    // Cycle-by-cycle comparison against the job model.
    always @(negedge clk) begin
        if (!reset) begin
            if (core_start) begin
                check("use_prev_cv", {159'd0, core_use_prev_cv}, {159'd0, m_start_cnt != 0});
                m_start_cnt++;
            end
            if (core_load) begin
                if (m_load_idx < m_nb * 16)
                    check("core_data", {128'd0, core_data}, {128'd0, m_words[m_load_idx]});
                else
                    check("extra_load", {159'd0, core_load}, 160'd0);
                if (m_load_idx == 0) m_first_word = core_data;
                m_load_idx++;
            end
            if (busy) check("core_cv", core_cv, m_cv_init);
            if (done) check("cv_out_done", cv_out, m_digest);
            check("busy_done_excl", {159'd0, busy & done}, 160'd0);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pack_data();
        for (int i = 0; i < 64; i++) data_i[i*32 +: 32] = tb_words[i];
    endtask

    task automatic load_abc();
        for (int i = 0; i < 64; i++) tb_words[i] = '0;
        tb_words[0] = 32'h61626380; tb_words[15] = 32'h00000018;
        pack_data();
    endtask

    task automatic load_448();
        logic [31:0] msg [14];
        msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
        for (int i = 0; i < 64; i++) tb_words[i] = '0;
        for (int i = 0; i < 14; i++) tb_words[i] = msg[i];
        tb_words[14] = 32'h80000000; tb_words[31] = 32'h000001c0;
        pack_data();
    endtask

    task automatic load_pattern(input logic [31:0] seed);
        for (int i = 0; i < 64; i++) tb_words[i] = (32'(i + 1) * 32'h9e3779b9) ^ seed;
        pack_data();
    endtask

    // Drives one start pulse from IDLE/FIN and records what the DUT must have latched.
    task automatic start_job(input int nb, input logic [159:0] cv);
        num_blocks = 3'(nb);
        cv_init    = cv;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        for (int i = 0; i < 64; i++) m_words[i] = tb_words[i];
        m_nb        = (nb > 4) ? 4 : nb;
        m_cv_init   = cv;
        m_digest    = model_chain(cv, m_nb);
        m_start_cnt = 0;
        m_load_idx  = 0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 500);
        check({nm, "_done_timeout"}, {159'd0, done}, 160'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; num_blocks = '0; data_i = '0;
        cv_init = '0; inj_valid = 1'b0; inj_cv = '0;
        m_nb = 0; m_start_cnt = 0; m_load_idx = 0; m_cv_init = '0; m_digest = '0; m_first_word = '0;
        for (int i = 0; i < 64; i++) begin tb_words[i] = '0; m_words[i] = '0; end
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", {159'd0, busy}, 160'd0);
        check("rst_done", {159'd0, done}, 160'd0);
        check("rst_cv_out", cv_out, 160'd0);
        check("rst_core_ctl", {157'd0, core_start, core_load, core_use_prev_cv}, 160'd0);
        check("rst_core_data", {128'd0, core_data}, 160'd0);
        check("rst_core_cv", core_cv, 160'd0);
        tick();
        reset = 1'b0;
        tick();

        // 1: "abc", single block
        load_abc();
        start_job(1, H_STD);
        check("model_pin_abc", m_digest, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
        wait_done("t1");
        check("t1_digest", cv_out, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
        check("t1_busy", {159'd0, busy}, 160'd0);
        check("t1_starts", 160'(m_start_cnt), 160'd1);
        check("t1_loads", 160'(m_load_idx), 160'd16);
        check("t1_first_word", {128'd0, m_first_word}, {128'd0, 32'h61626380});
        repeat (10) @(negedge clk);
        check("t1_sticky_done", {159'd0, done}, 160'd1);
        check("t1_sticky_cv", cv_out, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

        // 3: zero blocks, started from FIN
        begin
            logic saw_busy;
            saw_busy = 1'b0;
            start_job(0, 160'h01234567_89abcdef_fedcba98_76543210_deadbeef);
            @(negedge clk);
            check("t3_done", {159'd0, done}, 160'd1);
            check("t3_cv_out", cv_out, 160'h01234567_89abcdef_fedcba98_76543210_deadbeef);
            repeat (8) begin
                @(negedge clk);
                saw_busy = saw_busy | busy;
            end
            check("t3_busy_never", {159'd0, saw_busy}, 160'd0);
            check("t3_no_core_start", 160'(m_start_cnt), 160'd0);
        end

        // 2: two-block 448-bit message
        load_448();
        tick();
        start_job(2, H_STD);
        check("model_pin_448", m_digest, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);
        wait_done("t2");
        check("t2_digest", cv_out, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);
        check("t2_starts", 160'(m_start_cnt), 160'd2);

        // 4: num_blocks=7 clamps to 4
        load_pattern(32'h5a5a0000);
        tick();
        start_job(7, H_STD);
        wait_done("t4");
        check("t4_starts", 160'(m_start_cnt), 160'd4);
        check("t4_loads", 160'(m_load_idx), 160'd64);
        check("t4_digest", cv_out, model_chain(H_STD, 4));

        // 5: abort on word 5 of block 1, stray out_valid, then a clean rerun
        begin
            int nl, n;
            logic [159:0] mid;
            load_448();
            tick();
            start_job(2, H_STD);
            mid = sha1_compress(H_STD, m_block(0));
            nl = 0; n = 0;
            do begin
                @(negedge clk);
                n++;
                if (core_load) nl++;
            end while (!(core_load && nl == 22) && n < 200);
            check("t5_reach_word5", 160'(nl), 160'd22);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            check("t5_busy", {159'd0, busy}, 160'd0);
            check("t5_done", {159'd0, done}, 160'd0);
            check("t5_load_drop", {158'd0, core_load, core_start}, 160'd0);
            check("t5_cv_kept", cv_out, mid);
            repeat (3) tick();
            inj_cv    = 160'hffff0000_ffff0000_ffff0000_ffff0000_ffff0000;
            inj_valid = 1'b1;
            tick();
            inj_valid = 1'b0;
            repeat (2) @(negedge clk);
            check("t5_stray_done", {158'd0, done, busy}, 160'd0);
            check("t5_stray_cv", cv_out, mid);
            load_abc();
            tick();
            start_job(1, H_STD);
            wait_done("t5_rerun");
            check("t5_rerun_digest", cv_out, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
        end

        // 6a: start pulses mid-job and data_i changed after latching
        load_pattern(32'h13579bdf);
        tick();
        start_job(2, H_STD);
        load_pattern(32'hdeadbeef);
        for (int c = 1; c <= 32; c++) begin
            start      = (c == 3 || c == 12 || c == 20 || c == 30);
            num_blocks = 3'd1;
            tick();
        end
        start = 1'b0;
        wait_done("t6a");
        check("t6a_starts", 160'(m_start_cnt), 160'd2);
        check("t6a_digest", cv_out, model_chain(H_STD, 2));

        // 6b: reset while waiting on the core
        begin
            int nl, n;
            load_abc();
            tick();
            start_job(1, H_STD);
            nl = 0; n = 0;
            do begin
                @(negedge clk);
                n++;
                if (core_load) nl++;
            end while (!(!core_load && nl == 16) && n < 200);
            check("t6b_reach_wait", {159'd0, busy}, 160'd1);
            reset = 1'b1;
            @(negedge clk);
            check("t6b_rst_flags", {157'd0, busy, done, core_start}, 160'd0);
            check("t6b_rst_load", {158'd0, core_load, core_use_prev_cv}, 160'd0);
            check("t6b_rst_cv_out", cv_out, 160'd0);
            check("t6b_rst_core", {core_cv[127:0] | core_cv[159:32], core_data}, 160'd0);
            tick();
            reset = 1'b0;
            repeat (10) @(negedge clk);
            check("t6b_idle_after", {158'd0, busy, done}, 160'd0);
            check("t6b_cv_after", cv_out, 160'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
